// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the registered ALU: buffers {op,a,b} commands in a FIFO,
// issues one at a time, waits out the ALU latency and hands the result downstream.
module alu_cmd_sequencer #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic [2:0]             in_op,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [2:0]             alu_op,
  input  logic [2*WIDTH-1:0]     alu_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     out_result,
  output logic [2:0]             out_op,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err_illegal
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

  cmd_t            mem [DEPTH];
  cmd_t            head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   lat_cnt;
  state_t          state, state_next;
  logic            push, wr_en, pop, capture, lat_dec, release_out;

  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid & in_ready;
  // Opcodes 1xx are consumed from the interface but never stored.
  assign wr_en    = push & ~in_op[2];
  assign head     = mem[rd_ptr];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    capture     = 1'b0;
    lat_dec     = 1'b0;
    release_out = 1'b0;
    case (state)
      IDLE: if (count != '0) begin
        pop        = 1'b1;
        state_next = WAIT;
      end
      WAIT: if (lat_cnt != '0) begin
        lat_dec = 1'b1;
      end else begin
        capture    = 1'b1;
        state_next = HOLD;
      end
      HOLD: if (out_ready) begin
        release_out = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_op      <= '0;
      err_illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (pop) begin
        alu_a   <= head.a;
        alu_b   <= head.b;
        alu_op  <= head.op;
        lat_cnt <= LW'(ALU_LAT);
      end else if (lat_dec) begin
        lat_cnt <= lat_cnt - LW'(1);
      end
      if (capture) begin
        out_valid  <= 1'b1;
        out_result <= alu_result;
        out_op     <= alu_op;
      end else if (release_out) begin
        out_valid <= 1'b0;
      end
      if (push && in_op[2]) err_illegal <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= '{op: in_op, a: in_a, b: in_b};
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU plus a transaction-level model of
// the sequencer checked every cycle, with directed literal expectations on top.
module tb_alu_cmd_sequencer;

  localparam int WIDTH   = 4;
  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;
  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int RW      = 2 * WIDTH;

  logic             clk, rst;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [2:0]       alu_op;
  logic [RW-1:0]    alu_result;
  logic             out_valid, out_ready;
  logic [RW-1:0]    out_result;
  logic [2:0]       out_op;
  logic [CW-1:0]    count;
  logic             err_illegal;

  alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_op(out_op),
    .count(count), .err_illegal(err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU: divide by zero returns all ones.
  function automatic logic [RW-1:0] alu_fn(input logic [2:0] op, input logic [WIDTH-1:0] a, b);
    case (op)
      3'd0:    return RW'(a) + RW'(b);
      3'd1:    return RW'(a) - RW'(b);
      3'd2:    return RW'(a) * RW'(b);
      3'd3:    return (b == '0) ? '1 : RW'(a) / RW'(b);
      default: return '0;
    endcase
  endfunction

  logic [RW-1:0] alu_pipe [ALU_LAT];
  initial for (int i = 0; i < ALU_LAT; i++) alu_pipe[i] = '0;
  always @(posedge clk) begin
    alu_pipe[0] <= alu_fn(alu_op, alu_a, alu_b);
    for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_result = alu_pipe[ALU_LAT-1];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: queued commands, at most one outstanding, result visible
  // ALU_LAT+1 edges after issue, next issue one edge after the output handshake.
  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

  cmd_t m_fifo[$];
  cmd_t m_cmd, m_alu;
  bit   m_busy, m_err;
  int   m_cyc, m_issue, m_free_at;

  function automatic bit exp_valid();
    return m_busy && (m_cyc >= m_issue + ALU_LAT + 1);
  endfunction

  always @(posedge clk or negedge rst) begin
    bit v, can_push;
    if (!rst) begin
      m_fifo.delete();
      m_cmd = '{3'd0, '0, '0};
      m_alu = '{3'd0, '0, '0};
      m_busy = 0; m_err = 0; m_cyc = 0; m_issue = 0; m_free_at = 0;
    end else begin
      v        = exp_valid();
      can_push = in_valid && (m_fifo.size() != DEPTH);
      m_cyc++;
      if (v && out_ready) begin
        m_busy    = 0;
        m_free_at = m_cyc + 1;
      end
      if (!m_busy && m_cyc >= m_free_at && m_fifo.size() > 0) begin
        m_cmd   = m_fifo.pop_front();
        m_alu   = m_cmd;
        m_busy  = 1;
        m_issue = m_cyc;
      end
      if (can_push) begin
        if (in_op[2]) m_err = 1;
        else          m_fifo.push_back('{in_op, in_a, in_b});
      end
    end
  end

  logic [RW-1:0] got_res[$];
  logic [2:0]    got_op[$];

  always @(negedge clk) begin
    if (rst) begin
      check("in_ready", in_ready, (m_fifo.size() != DEPTH));
      check("count", count, m_fifo.size());
      check("out_valid", out_valid, exp_valid());
      check("err_illegal", err_illegal, m_err);
      check("alu_a", alu_a, m_alu.a);
      check("alu_b", alu_b, m_alu.b);
      check("alu_op", alu_op, m_alu.op);
      if (exp_valid()) begin
        check("out_result", out_result, alu_fn(m_cmd.op, m_cmd.a, m_cmd.b));
        check("out_op", out_op, m_cmd.op);
      end
      if (out_valid && out_ready) begin
        got_res.push_back(out_result);
        got_op.push_back(out_op);
      end
    end
  end

  task automatic push(input logic [2:0] op, input logic [WIDTH-1:0] a, b);
    bit ok = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = in_ready;
      @(posedge clk); #1;
    end
    check("push_accept", ok, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (m_fifo.size() == 0 && !m_busy) done = 1;
      else begin @(posedge clk); #1; end
    end
    check("drain", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  int base;

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
    #12;
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_alu", {alu_op, alu_a, alu_b}, 0);
    check("rst_out", {out_op, out_result}, 0);
    check("rst_err", err_illegal, 0);
    #5 rst = 1'b1;
    @(posedge clk); #1;

    // Single ADD: issue edge E0 follows the push, result visible two edges later.
    push(3'd0, 4'd5, 4'd3);
    @(posedge clk); #1;
    check("t1_alu", {alu_op, alu_a, alu_b}, {3'd0, 4'd5, 4'd3});
    check("t1_valid_e0", out_valid, 0);
    @(posedge clk); #1;
    check("t1_valid_e1", out_valid, 0);
    @(posedge clk); #1;
    check("t1_valid_e2", out_valid, 1);
    check("t1_result", out_result, 8);
    check("t1_op", out_op, 0);
    wait_drain();

    // Back-to-back SUB / MUL / DIV.
    base = got_res.size();
    push(3'd1, 4'd9, 4'd4);
    push(3'd2, 4'd2, 4'd3);
    push(3'd3, 4'd8, 4'd2);
    wait_drain();
    check("t2_n", got_res.size() - base, 3);
    check("t2_r0", {got_op[base],   got_res[base]},   {3'd1, 8'd5});
    check("t2_r1", {got_op[base+1], got_res[base+1]}, {3'd2, 8'd6});
    check("t2_r2", {got_op[base+2], got_res[base+2]}, {3'd3, 8'd4});

    // Fill with the output stalled.
    out_ready = 1'b0;
    base = got_res.size();
    for (int i = 1; i <= 5; i++) push(3'd0, 4'(i), 4'(i));
    check("t3_count_full", count, 4);
    check("t3_in_ready", in_ready, 0);
    check("t3_hold_valid", out_valid, 1);
    check("t3_hold_result", out_result, 2);
    repeat (3) @(posedge clk);
    #1 check("t3_still_held", {out_valid, out_result}, {1'b1, 8'd2});
    out_ready = 1'b1;
    push(3'd0, 4'd6, 4'd6);
    wait_drain();
    check("t3_n", got_res.size() - base, 6);
    for (int i = 0; i < 6; i++) check("t3_order", got_res[base+i], 2 * (i + 1));
    check("t3_count_empty", count, 0);

    // Illegal opcode between two ADDs.
    base = got_res.size();
    check("t4_err_before", err_illegal, 0);
    push(3'd0, 4'd1, 4'd2);
    push(3'b101, 4'd7, 4'd7);
    push(3'd0, 4'd3, 4'd4);
    check("t4_err_set", err_illegal, 1);
    wait_drain();
    check("t4_n", got_res.size() - base, 2);
    check("t4_r0", got_res[base], 3);
    check("t4_r1", got_res[base+1], 7);
    repeat (5) @(posedge clk);
    #1 check("t4_err_sticky", err_illegal, 1);

    // Divide by zero passes the ALU value straight through.
    base = got_res.size();
    push(3'd3, 4'd5, 4'd0);
    wait_drain();
    check("t6_n", got_res.size() - base, 1);
    check("t6_div0", {got_op[base], got_res[base]}, {3'd3, 8'hFF});

    // Asynchronous reset while WAITing with two commands queued.
    out_ready = 1'b0;
    push(3'd0, 4'd1, 4'd1);
    push(3'd0, 4'd2, 4'd2);
    push(3'd0, 4'd3, 4'd3);
    check("t5_count_pre", count, 2);
    #2 rst = 1'b0;
    #1;
    check("t5_count", count, 0);
    check("t5_in_ready", in_ready, 1);
    check("t5_out_valid", out_valid, 0);
    check("t5_alu", {alu_op, alu_a, alu_b}, 0);
    check("t5_out", {out_op, out_result}, 0);
    check("t5_err", err_illegal, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    out_ready = 1'b1;
    base = got_res.size();
    repeat (10) @(posedge clk);
    #1;
    check("t5_no_stale", got_res.size() - base, 0);
    check("t5_valid_low", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
